// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a byte stream (COUNT, 4*COUNT big-endian data bytes, CHECK), writes
// one 32-bit word per four data bytes, then validates an 8-bit additive
// checksum. The CPU is held while no good program is loaded.
module imem_loader #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Compare width wide enough for both the word counter and the count byte.
   localparam int CW = (ADDR_W >= 8) ? ADDR_W + 1 : 8;

   typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;

   state_t            state, state_nx;
   logic [7:0]        n_q;
   logic [1:0]        byte_cnt;
   logic [ADDR_W-1:0] word_cnt;
   logic [23:0]       word_q;
   logic [7:0]        csum;
   logic              xfer;
   logic              last_byte;
   logic              last_word;
   logic              count_bad;

   assign xfer      = byte_valid & byte_ready;
   assign last_byte = (byte_cnt == 2'd3);
   assign last_word = ((CW'(word_cnt) + CW'(1)) == CW'(n_q));
   assign count_bad = (byte_data == 8'd0) || (int'(byte_data) > DEPTH);
   assign busy      = (state == COUNT) || (state == DATA) || (state == CHECK);
   // Release the CPU only after a session that ended with a good checksum.
   assign cpu_hold  = ~done;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and handshake decode; byte_valid is used directly in the
   // accepting states so the decode does not loop through byte_ready.
   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = COUNT;
         COUNT: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nx = count_bad ? ERR : DATA;
         end
         DATA: begin
            byte_ready = 1'b1;
            if (byte_valid && last_byte && last_word) state_nx = CHECK;
         end
         CHECK: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nx = (byte_data == csum) ? DONE : ERR;
         end
         DONE:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: count latch, word assembly, write strobe, checksum, sticky flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_q      <= '0;
         byte_cnt <= '0;
         word_cnt <= '0;
         word_q   <= '0;
         csum     <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: if (start) begin
               done     <= 1'b0;
               err      <= 1'b0;
               n_q      <= '0;
               byte_cnt <= '0;
               word_cnt <= '0;
               csum     <= '0;
            end
            COUNT: if (xfer) begin
               n_q <= byte_data;
               if (count_bad) err <= 1'b1;
            end
            DATA: if (xfer) begin
               word_q   <= {word_q[15:0], byte_data};
               csum     <= csum + byte_data;
               byte_cnt <= byte_cnt + 2'd1;
               if (last_byte) begin
                  wr_en   <= 1'b1;
                  wr_data <= {word_q, byte_data};
                  wr_addr <= word_cnt;
                  // Hold at N-1 on the final word; no wrap.
                  if (!last_word) word_cnt <= word_cnt + 1'b1;
               end
            end
            CHECK: if (xfer) begin
               if (byte_data == csum) done <= 1'b1;
               else                   err  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the imem_loader byte-stream protocol.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulse_err = 0;
   int excl_err = 0;
   logic prev_wr = 1'b0;

   int          wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   int          xq[$];
   logic [7:0]  stim[$];

   imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Cycle counter.
   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en) begin
         wa.push_back(int'(wr_addr));
         wd.push_back(wr_data);
         wc.push_back(cyc);
      end
      if (wr_en && prev_wr) pulse_err <= pulse_err + 1;
      if (done && err) excl_err <= excl_err + 1;
      prev_wr <= wr_en;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete(); xq.delete();
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte and hold it until accepted (bounded).
   task automatic send_byte(input logic [7:0] b, input bit thr);
      int t;
      if (thr) begin
         t = 0;
         while ($urandom_range(0, 1) == 1 && t < 20) begin
            byte_valid = 1'b0;
            @(negedge clk);
            t++;
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
      xq.push_back(cyc + 1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_stim(input bit thr);
      foreach (stim[i]) send_byte(stim[i], thr);
   endtask

   task automatic wait_end();
      repeat (3) @(negedge clk);
   endtask

   task automatic check_two_words(input string tag);
      chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         chk({tag, "_a0"}, 32'(wa[0]), 32'd0);
         chk({tag, "_d0"}, wd[0], 32'h20020005);
         chk({tag, "_a1"}, 32'(wa[1]), 32'd1);
         chk({tag, "_d1"}, wd[1], 32'h2003000C);
      end
   endtask

   initial begin
      logic [31:0] ed[64];
      logic [7:0]  sum;
      int          bad;

      // Reset
      repeat (2) @(negedge clk);
      chk("rst_hold",  32'(cpu_hold),   32'd1);
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_done",  32'(done),       32'd0);
      chk("rst_err",   32'(err),        32'd0);
      chk("rst_wr",    32'(wr_en),      32'd0);
      chk("rst_ready", 32'(byte_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Good load: checksum 20+02+00+05+20+03+00+0C = 0x56
      clear_log();
      do_start();
      chk("start_busy", 32'(busy), 32'd1);
      stim = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C, 8'h56};
      send_stim(1'b0);
      wait_end();
      check_two_words("good");
      if (wc.size() == 2 && xq.size() == 10) begin
         chk("good_lat0", 32'(wc[0]), 32'(xq[4]));
         chk("good_lat1", 32'(wc[1]), 32'(xq[8]));
      end
      chk("good_done", 32'(done),     32'd1);
      chk("good_err",  32'(err),      32'd0);
      chk("good_hold", 32'(cpu_hold), 32'd0);
      chk("good_busy", 32'(busy),     32'd0);

      // Bad checksum
      clear_log();
      do_start();
      chk("bad_done_clr", 32'(done), 32'd0);
      stim[9] = 8'h57;
      send_stim(1'b0);
      wait_end();
      check_two_words("badck");
      chk("badck_err",  32'(err),      32'd1);
      chk("badck_hold", 32'(cpu_hold), 32'd1);
      chk("badck_done", 32'(done),     32'd0);

      // Bad counts: zero and DEPTH+1
      clear_log();
      do_start();
      send_byte(8'h00, 1'b0);
      wait_end();
      chk("cnt0_err", 32'(err), 32'd1);
      chk("cnt0_nwr", 32'(wa.size()), 32'd0);
      do_start();
      chk("cnt41_err_clr", 32'(err), 32'd0);
      send_byte(8'h41, 1'b0);
      wait_end();
      chk("cnt41_err",  32'(err),        32'd1);
      chk("cnt41_nwr",  32'(wa.size()),  32'd0);
      chk("cnt41_rdy",  32'(byte_ready), 32'd0);

      // Throttled good load
      clear_log();
      do_start();
      stim[9] = 8'h56;
      send_stim(1'b1);
      wait_end();
      check_two_words("thr");
      chk("thr_done", 32'(done), 32'd1);

      // Full 64-word load at one byte per cycle
      clear_log();
      stim.delete();
      stim.push_back(8'd64);
      sum = 8'h00;
      for (int i = 0; i < 64; i++) begin
         ed[i] = {8'(i), 8'hA5 ^ 8'(i), 8'h3C, 8'hFF - 8'(i)};
         for (int k = 3; k >= 0; k--) begin
            stim.push_back(ed[i][k*8 +: 8]);
            sum = sum + ed[i][k*8 +: 8];
         end
      end
      stim.push_back(sum);
      do_start();
      send_stim(1'b0);
      wait_end();
      chk("full_nwr", 32'(wa.size()), 32'd64);
      bad = 0;
      foreach (wa[i]) if (i < 64 && (wa[i] != i || wd[i] !== ed[i])) bad++;
      chk("full_words", 32'(bad), 32'd0);
      if (wa.size() > 0) chk("full_last_addr", 32'(wa[wa.size()-1]), 32'd63);
      chk("full_done", 32'(done), 32'd1);
      chk("wr_pulse_width", 32'(pulse_err), 32'd0);

      // Reset after 6 data bytes
      clear_log();
      do_start();
      stim = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03};
      send_stim(1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_busy",  32'(busy),       32'd0);
      chk("mid_hold",  32'(cpu_hold),   32'd1);
      chk("mid_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b1;
      byte_data  = 8'h00;
      repeat (8) @(negedge clk);
      byte_valid = 1'b0;
      chk("mid_nwr",  32'(wa.size()), 32'd1);
      chk("mid_done", 32'(done),      32'd0);

      // start during DATA and on the CHECK edge is ignored
      clear_log();
      do_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h02, 1'b0);
      start = 1'b1;
      send_byte(8'h00, 1'b0);
      start = 1'b0;
      stim = '{8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};
      send_stim(1'b0);
      start = 1'b1;
      send_byte(8'h56, 1'b0);
      start = 1'b0;
      @(negedge clk);
      check_two_words("sdata");
      chk("sdata_done", 32'(done), 32'd1);
      chk("sdone_busy", 32'(busy), 32'd0);
      // now in IDLE: start honoured
      do_start();
      chk("sidle_busy", 32'(busy), 32'd1);
      chk("sidle_done", 32'(done), 32'd0);
      chk("sidle_hold", 32'(cpu_hold), 32'd1);
      send_byte(8'h00, 1'b0);
      wait_end();
      chk("sidle_err", 32'(err), 32'd1);

      chk("done_err_excl", 32'(excl_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
